mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter between the instruction cache and data cache and the single RAM port. It accepts read requests from the icache and read/write requests from the dcache, grants one at a time through a registered FSM, and forwards the granted request to RAM. It holds the request until RAM reports ACCESS, then returns load data and releases the requester's wait. Dcache has priority; an optional fairness guard bounds icache starvation.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants with an icache request pending before the icache is forced a grant (fairness build only; range 1..15).
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache stall; 0 for exactly the completing cycle
- iload  out  32  icache read data; valid when iwait=0
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request; wins over dREN if both high
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  dcache stall; 0 for exactly the completing cycle
- dload  out  32  dcache read data; valid when dwait=0 on a read
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR

## Operation
- FSM states: IDLE, IGRANT, DGRANT. Reset to IDLE.
- IDLE: no RAM enables; both waits 1. Next state: DGRANT if (dREN|dWEN) and no forced icache grant; else IGRANT if iREN; else IDLE.
- DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN. iwait=1. When ramstate==ACCESS: dwait=0, dload=ramload, next IDLE. Otherwise dwait=1, stay.
- IGRANT: ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0. dwait=1. When ramstate==ACCESS: iwait=0, iload=ramload, next IDLE. Otherwise iwait=1, stay.
- ERROR, BUSY and FREE in a grant state: hold the request and keep wait=1. RAM retries; no arbiter-side abort.
- Abort: if the granted requester drops all its enables before ACCESS, drive the RAM enables to 0 that cycle and return to IDLE. No wait pulse is produced.
- iload and dload are 0 when their wait is 1. ramaddr and ramstore are 0 in IDLE.
- All outputs are combinational from state and inputs. Only state and the streak counter are registered.
- Reset values: state=IDLE, streak=0. Hence iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- Asynchronous reset mid-transaction drops the RAM enables immediately. The transaction is discarded.

## Timing
- Arbitration costs one cycle. A request seen in IDLE at cycle N drives RAM from cycle N+1.
- Earliest completion is the cycle N+1 ACCESS. The next grant decision is made in IDLE at cycle N+2. Minimum 2 cycles per transaction, no back-to-back grants.
- The requester must hold address, data and enables stable until its wait is 0. The arbiter does not latch them.
- Simultaneous dcache and icache requests in IDLE: dcache is granted, unless a forced grant applies.

## Configuration
- ARB_FAIRNESS_EN defined:
  - A streak counter (4 bits, saturating at STARVE_LIMIT) increments on each dcache completion where iREN=1.
  - It clears on any icache completion, and in IDLE when iREN=0.
  - In IDLE, if streak==STARVE_LIMIT and iREN=1, the next state is IGRANT regardless of dcache requests.
- ARB_FAIRNESS_EN undefined:
  - No counter.
  - Strict dcache priority; the icache may starve indefinitely.

## Test plan
- Reset with iREN=1: all outputs at reset values while nRST=0. First edge after release -> IGRANT; ramREN=1, ramaddr=iaddr.
- Icache read 0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> iwait=0, iload=0xDEADBEEF for one cycle, then IDLE.
- iREN=1 and dWEN=1 simultaneously in IDLE, daddr=0x100, dstore=0x12345678 -> DGRANT; ramWEN=1, ramREN=0, ramstore=0x12345678; iwait stays 1 until a later IGRANT completes.
- dREN and dWEN both 1 -> ramWEN=1, ramREN=0. Separately, dREN dropped during BUSY -> enables 0 that cycle, IDLE next, dwait never pulses 0.
- ramstate=ERROR for 3 cycles then ACCESS -> request held stable throughout; a single completion pulse on the ACCESS cycle.
- With ARB_FAIRNESS_EN and STARVE_LIMIT=4, continuous dcache reads plus iREN=1 -> the 5th grant goes to the icache; without the macro, the icache is never granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Icache/dcache to single RAM port arbiter: registered grant FSM, dcache priority.
// Define ARB_FAIRNESS_EN to add a streak counter that bounds icache starvation.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..15");
  end

  state_e state_q, state_d;
  logic   d_req;
  logic   ram_access;
  logic   force_i;

  assign d_req      = dREN | dWEN;
  assign ram_access = (ramstate == RAM_ACCESS);

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] streak_q, streak_d;

  assign force_i = iREN && (streak_q == LIMIT);

  always_comb begin
    streak_d = streak_q;
    unique case (state_q)
      IDLE:   if (!iREN) streak_d = '0;
      DGRANT: if (d_req && ram_access && iREN && streak_q < LIMIT) streak_d = streak_q + 4'd1;
      IGRANT: if (iREN && ram_access) streak_d = '0;
      default: streak_d = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) streak_q <= '0;
    else       streak_q <= streak_d;
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (force_i)    state_d = IGRANT;
        else if (d_req) state_d = DGRANT;
        else if (iREN)  state_d = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // Dropping both enables aborts silently: no RAM enables, no wait pulse.
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = dREN & ~dWEN;
          if (ram_access) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
          end
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ram_access) begin
            iwait   = 1'b0;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations hand-derived per cycle.
// Compile with +define+ARB_FAIRNESS_EN to exercise the forced icache grant.
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [3:0]  ctl;

  int total = 0;
  int bad   = 0;

  assign ctl = {iwait, dwait, ramREN, ramWEN};

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = 32'h1111_1111; ramstate = FREE;
    step(); step();
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL reset_ctl: got %b want 1100", ctl); end
    total++; if ({ramaddr, ramstore} !== 64'h0) begin bad++; $display("FAIL reset_ram: got %h/%h want 0/0", ramaddr, ramstore); end
    total++; if ({iload, dload} !== 64'h0) begin bad++; $display("FAIL reset_load: got %h/%h want 0/0", iload, dload); end
    nRST = 1'b1;
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL post_release_idle: got %b want 1100", ctl); end
    step();
    ramstate = BUSY;
    #1;
    total++; if (ctl !== 4'b1110 || ramaddr !== 32'h40) begin bad++; $display("FAIL first_igrant: got %b/%h want 1110/00000040", ctl, ramaddr); end
  endtask

  task automatic test_icache_read();
    step();
    #1;
    total++; if (ctl !== 4'b1110 || iload !== 32'h0) begin bad++; $display("FAIL ird_busy: got %b/%h want 1110/0", ctl, iload); end
    step();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    total++; if (ctl !== 4'b0110 || iload !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ird_done: got %b/%h want 0110/deadbeef", ctl, iload); end
    step();
    iREN = 1'b0; ramstate = FREE;
    #1;
    total++; if (ctl !== 4'b1100 || ramaddr !== 32'h0) begin bad++; $display("FAIL ird_idle: got %b/%h want 1100/0", ctl, ramaddr); end
  endtask

  task automatic test_priority();
    iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234_5678;
    step();
    ramstate = BUSY;
    #1;
    total++; if (ctl !== 4'b1101 || ramstore !== 32'h1234_5678 || ramaddr !== 32'h100)
      begin bad++; $display("FAIL prio_dgrant: got %b/%h/%h want 1101/00000100/12345678", ctl, ramaddr, ramstore); end
    step();
    ramstate = ACCESS;
    #1;
    total++; if (ctl !== 4'b1001) begin bad++; $display("FAIL prio_dwrite_done: got %b want 1001", ctl); end
    step();
    dWEN = 1'b0; ramstate = FREE;
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL prio_idle: got %b want 1100", ctl); end
    step();
    ramstate = ACCESS; ramload = 32'hCAFE_F00D;
    #1;
    total++; if (ctl !== 4'b0110 || iload !== 32'hCAFE_F00D || ramaddr !== 32'h80)
      begin bad++; $display("FAIL prio_iread_after: got %b/%h/%h want 0110/cafef00d/00000080", ctl, iload, ramaddr); end
    step();
    iREN = 1'b0; ramstate = FREE;
    #1;
  endtask

  task automatic test_both_enables();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hA5A5_A5A5;
    step();
    ramstate = BUSY;
    #1;
    total++; if (ctl !== 4'b1101) begin bad++; $display("FAIL both_en_busy: got %b want 1101", ctl); end
    step();
    ramstate = ACCESS;
    #1;
    total++; if (ctl !== 4'b1001) begin bad++; $display("FAIL both_en_done: got %b want 1001", ctl); end
    step();
    dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1;
  endtask

  task automatic test_abort();
    dREN = 1'b1; daddr = 32'h300;
    step();
    ramstate = BUSY;
    #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL abort_pre: got %b want 1110", ctl); end
    step();
    dREN = 1'b0;
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL abort_drop: got %b want 1100", ctl); end
    step();
    // Back in IDLE: a live read with ACCESS must still not complete this cycle.
    dREN = 1'b1; ramstate = ACCESS; ramload = 32'h0BAD_0BAD;
    #1;
    total++; if (ctl !== 4'b1100 || dload !== 32'h0) begin bad++; $display("FAIL abort_idle: got %b/%h want 1100/0", ctl, dload); end
    step();
    #1;
    total++; if (ctl !== 4'b1010 || dload !== 32'h0BAD_0BAD) begin bad++; $display("FAIL abort_regrant: got %b/%h want 1010/0bad0bad", ctl, dload); end
    step();
    dREN = 1'b0; ramstate = FREE;
    #1;
  endtask

  task automatic test_error_hold();
    iREN = 1'b1; iaddr = 32'h500;
    step();
    for (int i = 0; i < 3; i++) begin
      ramstate = ERROR;
      #1;
      total++; if (ctl !== 4'b1110 || ramaddr !== 32'h500 || iload !== 32'h0)
        begin bad++; $display("FAIL err_hold[%0d]: got %b/%h/%h want 1110/00000500/0", i, ctl, ramaddr, iload); end
      step();
    end
    ramstate = ACCESS; ramload = 32'h600D_600D;
    #1;
    total++; if (ctl !== 4'b0110 || iload !== 32'h600D_600D) begin bad++; $display("FAIL err_done: got %b/%h want 0110/600d600d", ctl, iload); end
    step();
    iREN = 1'b0; ramstate = FREE;
    #1;
    total++; if (ctl !== 4'b1100 || iload !== 32'h0) begin bad++; $display("FAIL err_single_pulse: got %b/%h want 1100/0", ctl, iload); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_w;
    iREN = 1'b1; iaddr = 32'h700; dREN = 1'b1; daddr = 32'h800;
    for (int g = 1; g <= 6; g++) begin
`ifdef ARB_FAIRNESS_EN
      exp_w = (g == 5) ? 2'b01 : 2'b10;
`else
      exp_w = 2'b10;
`endif
      step();
      ramstate = ACCESS; ramload = 32'(g);
      #1;
      total++; if ({iwait, dwait} !== exp_w) begin bad++; $display("FAIL fair_grant%0d: got iwait/dwait=%b want %b", g, {iwait, dwait}, exp_w); end
      step();
      ramstate = FREE;
      #1;
    end
    iREN = 1'b0; dREN = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    dREN = 1'b1; daddr = 32'h900;
    step();
    ramstate = BUSY;
    #1;
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL arst_pre: got %b want 1110", ctl); end
    #2 nRST = 1'b0;
    #1;
    total++; if (ctl !== 4'b1100 || ramaddr !== 32'h0) begin bad++; $display("FAIL arst_drop: got %b/%h want 1100/0", ctl, ramaddr); end
    dREN = 1'b0; ramstate = FREE;
    step();
    nRST = 1'b1;
    step();
    #1;
    total++; if (ctl !== 4'b1100) begin bad++; $display("FAIL arst_idle: got %b want 1100", ctl); end
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_priority();
    test_both_enables();
    test_abort();
    test_error_hold();
    test_fairness();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
